move_debouncer: RTL

MOVE_DEBOUNCER -- requirements
Module: move_debouncer

---
 rtl/move_debouncer_if.sv | 31 +++
 rtl/move_debouncer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/move_debouncer_if.sv
// Button/move bundle between the board inputs and the game FSM.
// Raw buttons are active-low; move pulses are active-high.
interface move_debouncer_if;
  logic btn_right_n;
  logic btn_left_n;
  logic btn_up_n;
  logic btn_down_n;
  logic busy;
  logic mov_right;
  logic mov_left;
  logic mov_up;
  logic mov_down;
  logic mov_pending;
  logic drop_flag;

  modport master (
    output btn_right_n, btn_left_n,
    output btn_up_n, btn_down_n, busy,
    input  mov_right, mov_left,
    input  mov_up, mov_down,
    input  mov_pending, drop_flag
  );

  modport slave (
    input  btn_right_n, btn_left_n,
    input  btn_up_n, btn_down_n, busy,
    output mov_right, mov_left,
    output mov_up, mov_down,
    output mov_pending, drop_flag
  );
endinterface

// File: rtl/move_debouncer.sv
// Four-button debouncer feeding a one-move-at-a-time pulse FSM.
// Bit order everywhere: 0=right 1=left 2=up 3=down (priority order).
module move_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            reset,
  move_debouncer_if.slave bus
);

  localparam logic [20:0] LIMIT = 21'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    EMIT,
    WAIT_REL
  } state_t;

  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] deb;
  logic [3:0] deb_q;
  logic [3:0] press;

  assign raw = {bus.btn_down_n, bus.btn_up_n,
                bus.btn_left_n, bus.btn_right_n};

  // Two-flop synchronizer; released (1) out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic [19:0] cnt_r;
    logic        lvl;
    logic [20:0] cnt_inc;

    assign cnt_inc = {1'b0, cnt_r} + 21'd1;
    assign deb[i]  = lvl;

    // Count consecutive mismatches; flip the level on the Nth one.
    always_ff @(posedge clk) begin
      if (!reset) begin
        cnt_r <= '0;
        lvl   <= 1'b1;
      end else if (sync2[i] == lvl) begin
        cnt_r <= '0;
      end else if (cnt_inc == LIMIT) begin
        cnt_r <= '0;
        lvl   <= ~lvl;
      end else begin
        cnt_r <= cnt_inc[19:0];
      end
    end
  end

  // Registered released-to-pressed edge of each debounced level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      deb_q <= '1;
      press <= '0;
    end else begin
      deb_q <= deb;
      press <= deb_q & ~deb;
    end
  end

  state_t     state;
  state_t     state_n;
  logic [3:0] dir;
  logic [3:0] dir_n;
  logic       drop;
  logic       drop_set;
  logic [3:0] pick;
  logic       multi;

  assign pick  = press & (~press + 4'd1);
  assign multi = |(press & (press - 4'd1));

  // State, captured direction and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      dir   <= '0;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      dir   <= dir_n;
      drop  <= drop | drop_set;
    end
  end

  // Next state; any press not taken in IDLE is dropped.
  always_comb begin
    state_n  = state;
    dir_n    = dir;
    drop_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (|press) begin
          dir_n    = pick;
          drop_set = multi;
          state_n  = bus.busy ? PEND : EMIT;
        end
      end
      PEND: begin
        drop_set = |press;
        if (!bus.busy) state_n = EMIT;
      end
      EMIT: begin
        drop_set = |press;
        state_n  = WAIT_REL;
      end
      WAIT_REL: begin
        drop_set = |press;
        if (&deb) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [3:0] mov;

  assign mov = (state == EMIT) ? dir : 4'b0000;

  assign bus.mov_right   = mov[0];
  assign bus.mov_left    = mov[1];
  assign bus.mov_up      = mov[2];
  assign bus.mov_down    = mov[3];
  assign bus.mov_pending = (state == PEND);
  assign bus.drop_flag   = drop;

endmodule
